// File: rtl/switch_debounce16.sv
// Switch input conditioner: 2-flop synchronizer plus independent per-bit debounce, with a change pulse.
// Optional sticky rising-edge flags are built when SWITCH_EDGE_LATCH_EN is defined.

module switch_debounce16_bit #(
   parameter int CNT_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic update
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 s1_q, s2_q;
   logic                 stable_q, stable_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Counter only advances while the synchronized level disagrees with the
   // debounced one, so any agreement restarts the persistence window.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      update   = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            update   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;

endmodule

module switch_debounce16 #(
   parameter int WIDTH           = 16,
   parameter int CNT_WIDTH       = 16,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic             sw_changed
`ifdef SWITCH_EDGE_LATCH_EN
   ,
   output logic [WIDTH-1:0] edge_latch,
   input  logic [WIDTH-1:0] edge_clear
`endif
);

   logic [WIDTH-1:0] upd;
   logic             sw_changed_q, sw_changed_d;

   switch_debounce16_bit #(
      .CNT_WIDTH      (CNT_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_bit [WIDTH-1:0] (
      .clk   (clk),
      .reset (reset),
      .raw   (sw_raw),
      .stable(sw_stable),
      .update(upd)
   );

   // Registered alongside the stable flops so the pulse lines up with the new value.
   assign sw_changed_d = |upd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sw_changed_q <= 1'b0;
      else       sw_changed_q <= sw_changed_d;
   end

   assign sw_changed = sw_changed_q;

`ifdef SWITCH_EDGE_LATCH_EN
   logic [WIDTH-1:0] edge_latch_q, edge_latch_d;

   // A bit updating while currently low is a 0->1 transition; set beats clear.
   assign edge_latch_d = (edge_latch_q & ~edge_clear) | (upd & ~sw_stable);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) edge_latch_q <= '0;
      else       edge_latch_q <= edge_latch_d;
   end

   assign edge_latch = edge_latch_q;
`endif

endmodule

// File: tb/tb_switch_debounce16.sv
// Bench for switch_debounce16 (DEBOUNCE_CYCLES=4): vector table, directed corner sequences,
// and randomized switch activity against a run-length reference model.
module tb_switch_debounce16;

   localparam int W = 16;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw_stable;
   logic         sw_changed;
   logic [W-1:0] edge_clear = '0;
`ifdef SWITCH_EDGE_LATCH_EN
   logic [W-1:0] edge_latch;
`endif

   always #5 clk = ~clk;

   switch_debounce16 #(.WIDTH(W), .CNT_WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_raw),
      .sw_stable (sw_stable),
      .sw_changed(sw_changed)
`ifdef SWITCH_EDGE_LATCH_EN
      ,
      .edge_latch(edge_latch),
      .edge_clear(edge_clear)
`endif
   );

   int checks = 0;
   int errors = 0;
   int npulse = 0;

   // Reference: two-sample delay line, then per bit the length of the current
   // run of samples that disagree with the reported level.
   logic [W-1:0] m_s1, m_s2, m_stable, m_latch;
   logic         m_changed;
   int           run [W];

   typedef struct {
      logic [W-1:0] raw;
      logic [W-1:0] st;
      logic         ch;
   } vec_t;
   vec_t tv [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_latch = '0; m_changed = 1'b0;
      for (int i = 0; i < W; i++) run[i] = 0;
   endtask

   task automatic model_edge();
      logic [W-1:0] flip;
      flip = '0;
      for (int i = 0; i < W; i++) begin
         if (m_s2[i] != m_stable[i]) run[i] = run[i] + 1;
         else run[i] = 0;
         if (run[i] == D) begin
            flip[i] = 1'b1;
            run[i]  = 0;
         end
      end
      m_latch   = (m_latch & ~edge_clear) | (flip & ~m_stable);
      m_stable  = m_stable ^ flip;
      m_changed = (flip != '0);
      m_s2      = m_s1;
      m_s1      = sw_raw;
   endtask

   task automatic step(input logic [W-1:0] raw);
      sw_raw = raw;
      @(posedge clk);
      model_edge();
      #1;
      chk("stable_vs_model", sw_stable, m_stable);
      chk("changed_vs_model", sw_changed, m_changed);
`ifdef SWITCH_EDGE_LATCH_EN
      chk("latch_vs_model", edge_latch, m_latch);
`endif
      if (sw_changed) npulse++;
   endtask

   task automatic do_reset(input logic [W-1:0] raw);
      sw_raw = raw;
      reset  = 1'b1;
      #3;
      model_reset();
      chk("reset_stable", sw_stable, 0);
      chk("reset_changed", sw_changed, 0);
`ifdef SWITCH_EDGE_LATCH_EN
      chk("reset_latch", edge_latch, 0);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      int ch_step;
      logic [W-1:0] r;

      tv[0] = '{16'h8082, 16'h0000, 1'b0};
      tv[1] = '{16'h8082, 16'h0000, 1'b0};
      tv[2] = '{16'h8082, 16'h0000, 1'b0};
      tv[3] = '{16'h8082, 16'h0000, 1'b0};
      tv[4] = '{16'h8082, 16'h0000, 1'b0};
      tv[5] = '{16'h8082, 16'h8082, 1'b1};
      tv[6] = '{16'h8082, 16'h8082, 1'b0};

      // Switches high through reset appear as one update after release.
      do_reset(16'hFFFF);
      npulse = 0;
      for (int k = 0; k < 7; k++) begin
         step(16'hFFFF);
         if (k == 4) chk("t1_before", sw_stable, 16'h0000);
         if (k == 5) begin
            chk("t1_stable", sw_stable, 16'hFFFF);
            chk("t1_pulse", sw_changed, 1);
         end
      end
      chk("t1_npulse", npulse, 1);

      // Bouncing bit 0, then settled high.
      do_reset('0);
      npulse  = 0;
      ch_step = -1;
      for (int k = 0; k < 30; k++) begin
         step((k < 20) ? {15'd0, ((k / 2) % 2 == 0)} : 16'h0001);
         if (ch_step < 0 && sw_stable[0]) ch_step = k;
      end
      chk("t2_change_step", ch_step, 25);
      chk("t2_npulse", npulse, 1);
      chk("t2_stable", sw_stable, 16'h0001);

      // Staggered rises give separate pulses.
      do_reset('0);
      npulse = 0;
      for (int k = 0; k < 10; k++) begin
         step((k < 2) ? 16'h0008 : 16'h0208);
         if (k == 5) chk("t3_first", {sw_changed, sw_stable}, 17'h10008);
         if (k == 6) chk("t3_gap", {sw_changed, sw_stable}, 17'h00008);
         if (k == 7) chk("t3_second", {sw_changed, sw_stable}, 17'h10208);
      end
      chk("t3_npulse", npulse, 2);

      // Simultaneous rises from the vector table.
      do_reset('0);
      for (int k = 0; k < 7; k++) begin
         step(tv[k].raw);
         chk($sformatf("t4_vec%0d_stable", k), sw_stable, tv[k].st);
         chk($sformatf("t4_vec%0d_changed", k), sw_changed, tv[k].ch);
      end

      // Reset mid-count drops the partial count.
      do_reset('0);
      npulse = 0;
      for (int k = 0; k < 4; k++) step(16'h0010);
      do_reset('0);
      for (int k = 0; k < 10; k++) step('0);
      chk("t5_stable", sw_stable, 16'h0000);
      chk("t5_npulse", npulse, 0);

`ifdef SWITCH_EDGE_LATCH_EN
      do_reset('0);
      for (int k = 0; k < 6; k++) step(16'h0020);
      chk("t6_set", edge_latch, 16'h0020);
      for (int k = 0; k < 6; k++) step('0);
      chk("t6_fall_keeps", edge_latch, 16'h0020);
      for (int k = 0; k < 6; k++) begin
         edge_clear = (k == 5) ? 16'h0020 : '0;
         step(16'h0020);
      end
      edge_clear = '0;
      chk("t6_set_wins", edge_latch, 16'h0020);
      step(16'h0020);
      edge_clear = 16'h0020;
      step(16'h0020);
      edge_clear = '0;
      chk("t6_clear", edge_latch, 16'h0000);
`endif

      // Random slowly-changing switches with occasional reset.
      do_reset('0);
      r = '0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < W; i++)
            if ($urandom_range(7) == 0) r[i] = ~r[i];
`ifdef SWITCH_EDGE_LATCH_EN
         edge_clear = W'($urandom) & W'($urandom) & W'($urandom);
`endif
         if ($urandom_range(299) == 0) do_reset(r);
         else step(r);
      end
      edge_clear = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
